io_stage: RTL and testbench
===========================

# io_stage

Memory-return stage of the five-stage MIPS pipeline, between EX and WB. It latches the EX result bus and captures synchronous data-SRAM read data for loads, holding it across WB back-pressure. It owns the HI/LO architectural registers and commits multiply, divide and MTHI/MTLO results to them. It produces the WB bus and the two-deep forwarding bus back to ID.

## Interface
Parameters:
- `CPU_DATA_WIDTH`, 32, datapath width; must match `cpu_core_params::CPU_DATA_WIDTH`.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ex_to_io_bus`  in  `ex_stage_params::EXToIOData`  EX result; `.valid` qualifies.
- `io_allow_in`  out  1  IO can accept `ex_to_io_bus` this cycle.
- `wb_allow_in`  in  1  WB accepts `io_to_wb_bus` this cycle.
- `data_ram_read_data`  in  32  SRAM read data; valid in the first cycle the load occupies IO.
- `io_to_wb_bus`  out  `io_stage_params::IOToWBData`  result to WB.
- `io_to_id_back_pass`  out  `io_stage_params::IOToIDBackPassData`  forwarding and hazard information.

## Operation
- Handshake:
  - `io_ready_go` = 1.
  - `io_allow_in` = !io_valid || wb_allow_in.
  - fire = io_valid && wb_allow_in.
- `io_valid`: when `io_allow_in`, loads `ex_to_io_bus.valid`; otherwise holds.
- The payload register loads only when `ex_to_io_bus.valid && io_allow_in`.
- Load buffer:
  - `first_cycle` is set on entry and cleared on the next edge.
  - In the first cycle, if the instruction is a load (`result_is_from_memory`) and not firing, capture `data_ram_read_data` into `load_buffer`.
  - Load data = first_cycle ? `data_ram_read_data` : `load_buffer`.
- HI/LO commit, on fire with `high_low_write`, in priority order:
  - `multiply_valid`: HI←product[63:32], LO←product[31:0].
  - `divide_valid && divide_result_valid`: LO←quotient, HI←remainder.
  - `result_high`: HI←`source_register_data`.
  - `result_low`: LO←`source_register_data`.
- `final_result`, in priority order:
  - `result_is_from_memory`: load data.
  - `!high_low_write && result_high` (MFHI): HI.
  - `!high_low_write && result_low` (MFLO): LO.
  - otherwise: `alu_result`.
- `io_to_wb_bus`:
  - `valid` = io_valid.
  - `program_count` from the payload register.
  - `final_result` as above.
  - `register_file_address` = `destination_register`.
  - `register_file_write_enabled` = `register_write`.
- Back pass, current stage:
  - `valid` = io_valid && register_write.
  - `write_register` = `destination_register`.
  - `write_data` = `final_result`.
- Back pass, previous stage: a register updated whenever `wb_allow_in`.
  - On fire, it loads the current triple.
  - Otherwise `previous_valid` ← 0.
  - It therefore mirrors the instruction now in WB.
- An MFHI/MFLO that immediately follows a HI/LO writer reads the committed value, because commit happens on the writer's fire edge.

## Timing
- Reset (asynchronous):
  - io_valid=0, first_cycle=0, HI=LO=0, load_buffer=0.
  - All previous_* fields = 0.
  - All output valid bits 0 from assertion, regardless of clock.
- Latency: one cycle from EX fire to `io_to_wb_bus.valid`. With `wb_allow_in` constantly 1, one instruction passes per cycle.
- Stall: outputs are held stable while `!wb_allow_in`. Load data survives any stall length via `load_buffer`.
- Simultaneous fire and enter: the payload register is overwritten; `first_cycle` is set for the new instruction. The HI/LO commit uses the old payload.
- Divide with `divide_result_valid`=0 must not reach IO. If it does, HI/LO are unchanged.
- Reset deasserted mid-stream: the first accepted instruction behaves as after a cold start.

## Configuration
- `CPU_HILO_EN` defined:
  - HI/LO registers, commit logic and MFHI/MFLO selection are present.
- `CPU_HILO_EN` undefined:
  - No HI/LO state.
  - multiply/divide/high_low_write fields are ignored.
  - MFHI/MFLO yield `alu_result`.

## Test plan
- Back-to-back ALU ops, PCs 0xBFC00000..0xBFC0000C, `wb_allow_in`=1 → four consecutive WB valids; each `final_result` = its `alu_result`; `previous_*` lags by one cycle.
- Load with `data_ram_read_data`=0xDEADBEEF in its first cycle, then `wb_allow_in`=0 for 3 cycles while the SRAM input changes to 0x0 → WB emits 0xDEADBEEF on release.
- MULT product 0x00000002_80000000, then MFHI, then MFLO → results 0x00000002 and 0x80000000.
- DIV quotient 7 remainder 3, then MTLO source 0x1234, then MFLO/MFHI → 0x1234 and 3.
- `reset_n` asserted while a load is stalled in IO → all valids drop immediately with no clock; after release, the next instruction flows normally with HI=LO=0.
- Build without `CPU_HILO_EN`, MULT then MFHI with `alu_result`=0x55 → result 0x55, no HI state.

Source files
------------

// File: rtl/io_stage.sv
// ----------------------------------------------------------------------------
// io_stage : memory-return stage of the five-stage MIPS pipeline (EX -> WB).
//
// Latches the EX result bus, captures synchronous data-SRAM read data for
// loads (buffered so it survives WB back-pressure), owns the HI/LO
// architectural registers and produces the WB bus plus a two-deep forwarding
// bus back to ID.
//
// Optional feature macro: CPU_HILO_EN
//   defined   -> HI/LO registers, multiply/divide/MTHI/MTLO commit and
//                MFHI/MFLO result selection are built.
//   undefined -> no HI/LO state; MFHI/MFLO simply return alu_result.
//
// Ports:
//   clock               sole clock, rising edge
//   reset_n             asynchronous active-low reset
//   ex_to_io_bus        EX result payload, .valid qualifies
//   io_allow_in         stage can accept ex_to_io_bus this cycle
//   wb_allow_in         WB accepts io_to_wb_bus this cycle
//   data_ram_read_data  SRAM read data, valid in a load's first IO cycle
//   io_to_wb_bus        result towards WB
//   io_to_id_back_pass  forwarding info: current IO instr and instr in WB
// ----------------------------------------------------------------------------

package cpu_core_params;
  localparam int CPU_DATA_WIDTH = 32;
endpackage

package ex_stage_params;
  localparam int W = cpu_core_params::CPU_DATA_WIDTH;

  typedef struct packed {
    logic           valid;
    logic [W-1:0]   program_count;
    logic [W-1:0]   alu_result;
    logic [W-1:0]   source_register_data;
    logic           result_is_from_memory;
    logic           high_low_write;
    logic           result_high;
    logic           result_low;
    logic           multiply_valid;
    logic [2*W-1:0] multiply_product;
    logic           divide_valid;
    logic           divide_result_valid;
    logic [W-1:0]   divide_quotient;
    logic [W-1:0]   divide_remainder;
    logic [4:0]     destination_register;
    logic           register_write;
  } EXToIOData;
endpackage

package io_stage_params;
  localparam int W = cpu_core_params::CPU_DATA_WIDTH;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] program_count;
    logic [W-1:0] final_result;
    logic [4:0]   register_file_address;
    logic         register_file_write_enabled;
  } IOToWBData;

  typedef struct packed {
    logic         valid;
    logic [4:0]   write_register;
    logic [W-1:0] write_data;
    logic         previous_valid;
    logic [4:0]   previous_write_register;
    logic [W-1:0] previous_write_data;
  } IOToIDBackPassData;
endpackage

module io_stage #(
  parameter int CPU_DATA_WIDTH = 32
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  ex_stage_params::EXToIOData          ex_to_io_bus,
  output logic                                io_allow_in,
  input  logic                                wb_allow_in,
  input  logic [31:0]                         data_ram_read_data,
  output io_stage_params::IOToWBData          io_to_wb_bus,
  output io_stage_params::IOToIDBackPassData  io_to_id_back_pass
);

  ex_stage_params::EXToIOData r_payload;
  logic                       r_io_valid;
  logic                       r_first_cycle;
  logic [CPU_DATA_WIDTH-1:0]  r_load_buffer;
  logic                       r_prev_valid;
  logic [4:0]                 r_prev_write_register;
  logic [CPU_DATA_WIDTH-1:0]  r_prev_write_data;

  logic                       w_allow_in;
  logic                       w_fire;
  logic                       w_enter;
  logic                       w_bp_valid;
  logic [CPU_DATA_WIDTH-1:0]  w_load_data;
  logic [CPU_DATA_WIDTH-1:0]  w_final_result;

  // io_ready_go is constantly 1, so the handshake reduces to these terms.
  assign w_allow_in = !r_io_valid || wb_allow_in;
  assign w_fire     = r_io_valid && wb_allow_in;
  assign w_enter    = ex_to_io_bus.valid && w_allow_in;
  assign w_bp_valid = r_io_valid && r_payload.register_write;

  // first_cycle marks the single cycle in which SRAM read data is live.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_io_valid    <= 1'b0;
      r_first_cycle <= 1'b0;
      r_payload     <= '0;
    end else begin
      if (w_allow_in) r_io_valid <= ex_to_io_bus.valid;
      if (w_enter)    r_payload  <= ex_to_io_bus;
      r_first_cycle <= w_enter;
    end
  end

  // A load that cannot leave in its first cycle keeps its SRAM data here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_load_buffer <= '0;
    end else if (r_first_cycle && r_payload.result_is_from_memory && !w_fire) begin
      r_load_buffer <= data_ram_read_data;
    end
  end

  assign w_load_data = r_first_cycle ? data_ram_read_data : r_load_buffer;

`ifdef CPU_HILO_EN
  logic [CPU_DATA_WIDTH-1:0] r_hi;
  logic [CPU_DATA_WIDTH-1:0] r_lo;

  // Commit on the writer's fire edge so a directly following MFHI/MFLO
  // already sees the new value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fire && r_payload.high_low_write) begin
      if (r_payload.multiply_valid) begin
        r_hi <= r_payload.multiply_product[2*CPU_DATA_WIDTH-1:CPU_DATA_WIDTH];
        r_lo <= r_payload.multiply_product[CPU_DATA_WIDTH-1:0];
      end else if (r_payload.divide_valid && r_payload.divide_result_valid) begin
        r_lo <= r_payload.divide_quotient;
        r_hi <= r_payload.divide_remainder;
      end else if (r_payload.result_high) begin
        r_hi <= r_payload.source_register_data;
      end else if (r_payload.result_low) begin
        r_lo <= r_payload.source_register_data;
      end
    end
  end

  logic w_unused_fields;
  assign w_unused_fields = r_payload.valid;
`else
  logic w_unused_fields;
  assign w_unused_fields = ^{r_payload.valid, r_payload.source_register_data,
                             r_payload.high_low_write, r_payload.result_high,
                             r_payload.result_low, r_payload.multiply_valid,
                             r_payload.multiply_product, r_payload.divide_valid,
                             r_payload.divide_result_valid, r_payload.divide_quotient,
                             r_payload.divide_remainder};
`endif

  // Result select: memory first, then MFHI/MFLO (only when HI/LO exists).
  always_comb begin
    w_final_result = r_payload.alu_result;
    if (r_payload.result_is_from_memory) begin
      w_final_result = w_load_data;
    end
`ifdef CPU_HILO_EN
    else if (!r_payload.high_low_write && r_payload.result_high) begin
      w_final_result = r_hi;
    end else if (!r_payload.high_low_write && r_payload.result_low) begin
      w_final_result = r_lo;
    end
`endif
  end

  // Previous-stage forwarding entry mirrors whatever now sits in WB.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_valid          <= 1'b0;
      r_prev_write_register <= '0;
      r_prev_write_data     <= '0;
    end else if (wb_allow_in) begin
      if (w_fire) begin
        r_prev_valid          <= w_bp_valid;
        r_prev_write_register <= r_payload.destination_register;
        r_prev_write_data     <= w_final_result;
      end else begin
        r_prev_valid <= 1'b0;
      end
    end
  end

  assign io_allow_in = w_allow_in;

  always_comb begin
    io_to_wb_bus                             = '0;
    io_to_wb_bus.valid                       = r_io_valid;
    io_to_wb_bus.program_count               = r_payload.program_count;
    io_to_wb_bus.final_result                = w_final_result;
    io_to_wb_bus.register_file_address       = r_payload.destination_register;
    io_to_wb_bus.register_file_write_enabled = r_payload.register_write;
  end

  always_comb begin
    io_to_id_back_pass                         = '0;
    io_to_id_back_pass.valid                   = w_bp_valid;
    io_to_id_back_pass.write_register          = r_payload.destination_register;
    io_to_id_back_pass.write_data              = w_final_result;
    io_to_id_back_pass.previous_valid          = r_prev_valid;
    io_to_id_back_pass.previous_write_register = r_prev_write_register;
    io_to_id_back_pass.previous_write_data     = r_prev_write_data;
  end

endmodule

// File: tb/tb_io_stage.sv
// ----------------------------------------------------------------------------
// tb_io_stage : self-checking bench for io_stage.
// A transaction-level model tracks the instruction held in IO, the HI/LO
// values and the instruction held in WB; every cycle the DUT outputs are
// compared against it. Directed sequences pin the model with literal values,
// then a randomized run exercises stalls, loads and HI/LO traffic.
// ----------------------------------------------------------------------------
module tb_io_stage;
  import ex_stage_params::*;
  import io_stage_params::*;

  typedef enum {K_ALU, K_LOAD, K_MULT, K_DIV, K_MTHI, K_MTLO, K_MFHI, K_MFLO} kind_e;

  logic              clock = 1'b0;
  logic              resetN;
  EXToIOData         exBus;
  logic              ioAllowIn;
  logic              wbAllowIn;
  logic [31:0]       ramData;
  IOToWBData         wbBus;
  IOToIDBackPassData backPass;

  always #5 clock = ~clock;

  io_stage #(.CPU_DATA_WIDTH(32)) dut (
    .clock              (clock),
    .reset_n            (resetN),
    .ex_to_io_bus       (exBus),
    .io_allow_in        (ioAllowIn),
    .wb_allow_in        (wbAllowIn),
    .data_ram_read_data (ramData),
    .io_to_wb_bus       (wbBus),
    .io_to_id_back_pass (backPass)
  );

  int checks = 0;
  int errors = 0;

  // Model state: instruction in IO, its load value, HI/LO, instruction in WB.
  bit          mOccupied;
  EXToIOData   mIns;
  bit          mFreshEntry;
  logic [31:0] mLoadValue;
  logic [31:0] mHi, mLo;
  bit          mPrevValid;
  logic [4:0]  mPrevReg;
  logic [31:0] mPrevData;

  IOToWBData         sWb;
  IOToIDBackPassData sBp;
  logic              sAllow;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mOccupied = 0; mIns = '0; mFreshEntry = 0; mLoadValue = '0;
    mHi = '0; mLo = '0; mPrevValid = 0; mPrevReg = '0; mPrevData = '0;
  endtask

  function automatic logic [31:0] modelResult();
    if (mIns.result_is_from_memory) return mLoadValue;
`ifdef CPU_HILO_EN
    if (!mIns.high_low_write && mIns.result_high) return mHi;
    if (!mIns.high_low_write && mIns.result_low)  return mLo;
`endif
    return mIns.alu_result;
  endfunction

  // Compare sampled DUT outputs against the model for the current cycle.
  task automatic checkOutput();
    logic [31:0] expFinal;
    if (mOccupied && mFreshEntry) mLoadValue = ramData;
    expFinal = modelResult();
    checkVal("io_allow_in", sAllow, !mOccupied || wbAllowIn);
    checkVal("wb_valid", sWb.valid, mOccupied);
    checkVal("bp_valid", sBp.valid, mOccupied && mIns.register_write);
    if (mOccupied) begin
      checkVal("wb_pc", sWb.program_count, mIns.program_count);
      checkVal("wb_final", sWb.final_result, expFinal);
      checkVal("wb_addr", sWb.register_file_address, mIns.destination_register);
      checkVal("wb_we", sWb.register_file_write_enabled, mIns.register_write);
      checkVal("bp_reg", sBp.write_register, mIns.destination_register);
      checkVal("bp_data", sBp.write_data, expFinal);
    end
    checkVal("prev_valid", sBp.previous_valid, mPrevValid);
    if (mPrevValid) begin
      checkVal("prev_reg", sBp.previous_write_register, mPrevReg);
      checkVal("prev_data", sBp.previous_write_data, mPrevData);
    end
  endtask

  // Advance the model across one rising edge using the inputs that were driven.
  task automatic modelClock();
    logic [31:0] res;
    if (mOccupied && wbAllowIn) begin
      res = modelResult();
`ifdef CPU_HILO_EN
      if (mIns.high_low_write) begin
        if (mIns.multiply_valid) {mHi, mLo} = mIns.multiply_product;
        else if (mIns.divide_valid && mIns.divide_result_valid) begin
          mLo = mIns.divide_quotient; mHi = mIns.divide_remainder;
        end
        else if (mIns.result_high) mHi = mIns.source_register_data;
        else if (mIns.result_low)  mLo = mIns.source_register_data;
      end
`endif
      mPrevValid = mIns.register_write;
      mPrevReg   = mIns.destination_register;
      mPrevData  = res;
    end else if (wbAllowIn) begin
      mPrevValid = 0;
    end
    mFreshEntry = 0;
    if (!mOccupied || wbAllowIn) begin
      mOccupied = exBus.valid;
      if (exBus.valid) begin
        mIns = exBus;
        mFreshEntry = 1;
      end
    end
  endtask

  task automatic applyStimulus(input EXToIOData ins, input bit wb, input logic [31:0] ram);
    @(negedge clock);
    exBus = ins; wbAllowIn = wb; ramData = ram;
    #1;
    sWb = wbBus; sBp = backPass; sAllow = ioAllowIn;
    checkOutput();
    @(posedge clock);
    modelClock();
  endtask

  function automatic EXToIOData mkIns(input kind_e k, input logic [31:0] pc,
                                      input logic [31:0] alu, input logic [4:0] dest);
    EXToIOData t;
    t = '0;
    t.valid = 1'b1; t.program_count = pc; t.alu_result = alu;
    t.destination_register = dest; t.register_write = 1'b1;
    case (k)
      K_LOAD: t.result_is_from_memory = 1'b1;
      K_MULT: begin t.high_low_write = 1; t.multiply_valid = 1; t.register_write = 0; end
      K_DIV:  begin t.high_low_write = 1; t.divide_valid = 1; t.divide_result_valid = 1; t.register_write = 0; end
      K_MTHI: begin t.high_low_write = 1; t.result_high = 1; t.register_write = 0; end
      K_MTLO: begin t.high_low_write = 1; t.result_low = 1; t.register_write = 0; end
      K_MFHI: t.result_high = 1'b1;
      K_MFLO: t.result_low = 1'b1;
      default: ;
    endcase
    return t;
  endfunction

  function automatic EXToIOData randIns();
    EXToIOData t;
    kind_e k;
    k = kind_e'($urandom_range(0, 7));
    t = mkIns(k, $urandom, $urandom, 5'($urandom_range(0, 31)));
    t.valid = ($urandom_range(0, 9) < 7);
    t.source_register_data = $urandom;
    t.multiply_product = {$urandom, $urandom};
    t.divide_quotient = $urandom;
    t.divide_remainder = $urandom;
    if (k == K_ALU || k == K_LOAD) t.register_write = 1'($urandom_range(0, 1));
    if (k == K_LOAD) begin
      t.result_high = 1'($urandom_range(0, 1));
      t.result_low  = 1'($urandom_range(0, 1));
    end
    if (k == K_MULT) begin
      t.result_high = 1'($urandom_range(0, 1));
      t.result_low  = 1'($urandom_range(0, 1));
    end
    if (k == K_DIV) begin
      t.divide_result_valid = 1'($urandom_range(0, 1));
      if (t.divide_result_valid) t.result_high = 1'($urandom_range(0, 1));
    end
    return t;
  endfunction

  EXToIOData idle;
  EXToIOData t;

  initial begin
    idle = '0;
    resetN = 1'b0; exBus = '0; wbAllowIn = 1'b0; ramData = '0;
    modelReset();
    #2;
    checkVal("rst_wb_valid", wbBus.valid, 1'b0);
    checkVal("rst_bp_valid", backPass.valid, 1'b0);
    checkVal("rst_prev_valid", backPass.previous_valid, 1'b0);
    checkVal("rst_allow", ioAllowIn, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;

    // Back-to-back ALU ops, WB always ready.
    applyStimulus(mkIns(K_ALU, 32'hBFC00000, 32'h11, 5'd1), 1, 0);
    checkVal("b2b_empty", sWb.valid, 1'b0);
    applyStimulus(mkIns(K_ALU, 32'hBFC00004, 32'h22, 5'd2), 1, 0);
    checkVal("b2b0_final", sWb.final_result, 32'h11);
    checkVal("b2b0_pc", sWb.program_count, 32'hBFC00000);
    checkVal("b2b0_prev", sBp.previous_valid, 1'b0);
    applyStimulus(mkIns(K_ALU, 32'hBFC00008, 32'h33, 5'd3), 1, 0);
    checkVal("b2b1_final", sWb.final_result, 32'h22);
    checkVal("b2b1_prev", sBp.previous_write_data, 32'h11);
    applyStimulus(mkIns(K_ALU, 32'hBFC0000C, 32'h44, 5'd4), 1, 0);
    checkVal("b2b2_final", sWb.final_result, 32'h33);
    applyStimulus(idle, 1, 0);
    checkVal("b2b3_final", sWb.final_result, 32'h44);
    checkVal("b2b3_pc", sWb.program_count, 32'hBFC0000C);
    applyStimulus(idle, 1, 0);
    checkVal("b2b_prev_last", sBp.previous_write_data, 32'h44);

    // Load held across a 3-cycle stall while SRAM data changes.
    applyStimulus(mkIns(K_LOAD, 32'hBFC00010, 32'h0, 5'd5), 1, 32'h0);
    applyStimulus(idle, 0, 32'hDEADBEEF);
    checkVal("ld_first", sWb.final_result, 32'hDEADBEEF);
    applyStimulus(idle, 0, 32'h0);
    applyStimulus(idle, 0, 32'h0);
    checkVal("ld_stalled", sWb.final_result, 32'hDEADBEEF);
    applyStimulus(idle, 1, 32'h0);
    checkVal("ld_release", sWb.final_result, 32'hDEADBEEF);
    applyStimulus(idle, 1, 32'h0);
    checkVal("ld_prev", sBp.previous_write_data, 32'hDEADBEEF);

    // MULT then MFHI then MFLO.
    t = mkIns(K_MULT, 32'hBFC00020, 32'h0, 5'd0);
    t.multiply_product = 64'h00000002_80000000;
    applyStimulus(t, 1, 0);
    applyStimulus(mkIns(K_MFHI, 32'hBFC00024, 32'h55, 5'd6), 1, 0);
    applyStimulus(mkIns(K_MFLO, 32'hBFC00028, 32'h66, 5'd7), 1, 0);
`ifdef CPU_HILO_EN
    checkVal("mfhi_mult", sWb.final_result, 32'h00000002);
`else
    checkVal("mfhi_nohilo", sWb.final_result, 32'h55);
`endif
    applyStimulus(idle, 1, 0);
`ifdef CPU_HILO_EN
    checkVal("mflo_mult", sWb.final_result, 32'h80000000);
`else
    checkVal("mflo_nohilo", sWb.final_result, 32'h66);
`endif

    // DIV, MTLO, then MFLO / MFHI.
    t = mkIns(K_DIV, 32'hBFC00030, 32'h0, 5'd0);
    t.divide_quotient = 32'd7; t.divide_remainder = 32'd3;
    applyStimulus(t, 1, 0);
    t = mkIns(K_MTLO, 32'hBFC00034, 32'h0, 5'd0);
    t.source_register_data = 32'h1234;
    applyStimulus(t, 1, 0);
    applyStimulus(mkIns(K_MFLO, 32'hBFC00038, 32'h77, 5'd8), 1, 0);
    applyStimulus(mkIns(K_MFHI, 32'hBFC0003C, 32'h88, 5'd9), 1, 0);
`ifdef CPU_HILO_EN
    checkVal("mflo_mtlo", sWb.final_result, 32'h1234);
`else
    checkVal("mflo_nohilo2", sWb.final_result, 32'h77);
`endif
    applyStimulus(idle, 1, 0);
`ifdef CPU_HILO_EN
    checkVal("mfhi_div", sWb.final_result, 32'd3);
`else
    checkVal("mfhi_nohilo2", sWb.final_result, 32'h88);
`endif

    // Asynchronous reset while a load is stalled in IO.
    applyStimulus(mkIns(K_LOAD, 32'hBFC00040, 32'h0, 5'd10), 1, 0);
    applyStimulus(idle, 0, 32'hABCD);
    exBus = idle;
    #2 resetN = 1'b0;
    #1;
    checkVal("arst_wb_valid", wbBus.valid, 1'b0);
    checkVal("arst_bp_valid", backPass.valid, 1'b0);
    checkVal("arst_prev_valid", backPass.previous_valid, 1'b0);
    checkVal("arst_allow", ioAllowIn, 1'b1);
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    applyStimulus(mkIns(K_ALU, 32'hBFC00050, 32'h5A, 5'd11), 1, 0);
    applyStimulus(mkIns(K_MFHI, 32'hBFC00054, 32'h99, 5'd12), 1, 0);
    checkVal("post_rst_alu", sWb.final_result, 32'h5A);
    applyStimulus(idle, 1, 0);
`ifdef CPU_HILO_EN
    checkVal("post_rst_hi", sWb.final_result, 32'h0);
`else
    checkVal("post_rst_nohilo", sWb.final_result, 32'h99);
`endif

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(randIns(), ($urandom_range(0, 3) != 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
